// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset datapath: fetch, decode, execute, memory, writeback.
// Strobes are decoded combinationally from state and instr; instret, illegal and the wait counter are registered.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter logic [31:0] INSTRET_RST = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        cmp_lt,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic [5:0]  alu_op,
  output logic        alu_src_b,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ILL, C_R, C_ADDI, C_JAL, C_BEQ, C_BLT, C_LW, C_SW
  } cls_t;

  state_t      st;
  cls_t        dec_cls;
  logic [5:0]  dec_op;
  logic [31:0] tmo_cnt;
  logic        timed_out;
  logic        unused_instr;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode       = instr[6:0];
  assign f3           = instr[14:12];
  assign f7           = instr[31:25];
  assign unused_instr = ^{instr[24:15], instr[11:7]};
  assign state        = st;
  assign timed_out    = (MEM_TIMEOUT != 0) && (tmo_cnt == 32'(MEM_TIMEOUT - 1));

  always_comb begin
    dec_cls = C_ILL;
    dec_op  = '0;
    case (opcode)
      7'b0110011: begin
        case (f3)
          3'b000: begin
            if (f7 == 7'b0000000) begin dec_cls = C_R; dec_op = 6'b000001; end
            else if (f7 == 7'b0100000) begin dec_cls = C_R; dec_op = 6'b000010; end
          end
          3'b001: if (f7 == 7'b0000000) begin dec_cls = C_R; dec_op = 6'b000011; end
          3'b111: if (f7 == 7'b0000000) begin dec_cls = C_R; dec_op = 6'b000110; end
          3'b110: if (f7 == 7'b0000000) begin dec_cls = C_R; dec_op = 6'b000111; end
          3'b100: if (f7 == 7'b0000000) begin dec_cls = C_R; dec_op = 6'b001000; end
          3'b101: if (f7 == 7'b0000000) begin dec_cls = C_R; dec_op = 6'b001011; end
          default: ;
        endcase
      end
      7'b0010011: if (f3 == 3'b000) begin dec_cls = C_ADDI; dec_op = 6'b000101; end
      7'b1101111: begin dec_cls = C_JAL; dec_op = 6'b000100; end
      7'b1100011: begin
        if (f3 == 3'b000) begin dec_cls = C_BEQ; dec_op = 6'b001010; end
        else if (f3 == 3'b100) begin dec_cls = C_BLT; dec_op = 6'b001001; end
      end
      7'b0000011: if (f3 == 3'b010) begin dec_cls = C_LW; dec_op = 6'b001100; end
      7'b0100011: if (f3 == 3'b010) begin dec_cls = C_SW; dec_op = 6'b001101; end
      default: ;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    alu_op       = '0;
    alu_src_b    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'd0;
    // alu_op/alu_src_b stay valid from DECODE through WB so the ALU result is stable for MEM
    if (st == S_DECODE || st == S_EXEC || st == S_MEM || st == S_WB) begin
      alu_op    = dec_op;
      alu_src_b = (dec_cls == C_ADDI) || (dec_cls == C_LW) || (dec_cls == C_SW);
    end
    case (st)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_EXEC: begin
        if (dec_cls == C_BEQ) begin pc_we = 1'b1; pc_src = alu_zero; end
        else if (dec_cls == C_BLT) begin pc_we = 1'b1; pc_src = cmp_lt; end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (dec_cls == C_SW);
        pc_we        = mem_ready && (dec_cls == C_SW);
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        pc_src = (dec_cls == C_JAL);
        wb_sel = (dec_cls == C_LW) ? 2'd1 : (dec_cls == C_JAL) ? 2'd2 : 2'd0;
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 1'b0;
      alu_op       = '0;
      alu_src_b    = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= S_FETCH;
      instret <= INSTRET_RST;
      illegal <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (pc_we) instret <= instret + 32'd1;
      case (st)
        S_FETCH: begin
          if (mem_ready) st <= S_DECODE;
          else if (timed_out) begin st <= S_TRAP; illegal <= 1'b1; end
          else tmo_cnt <= tmo_cnt + 32'd1;
        end
        S_DECODE: begin
          if (dec_cls == C_ILL) begin st <= S_TRAP; illegal <= 1'b1; end
          else st <= S_EXEC;
        end
        S_EXEC: begin
          case (dec_cls)
            C_LW, C_SW:   begin st <= S_MEM; tmo_cnt <= '0; end
            C_BEQ, C_BLT: begin st <= S_FETCH; tmo_cnt <= '0; end
            C_ILL:        begin st <= S_TRAP; illegal <= 1'b1; end
            default:      st <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (dec_cls == C_LW) st <= S_WB;
            else begin st <= S_FETCH; tmo_cnt <= '0; end
          end else if (timed_out) begin
            st <= S_TRAP; illegal <= 1'b1;
          end else tmo_cnt <= tmo_cnt + 32'd1;
        end
        S_WB: begin
          st      <= S_FETCH;
          tmo_cnt <= '0;
        end
        S_TRAP: st <= S_TRAP;
        default: begin st <= S_TRAP; illegal <= 1'b1; end
      endcase
    end
  end

endmodule
